// File: rtl/out_mem_streamer_pkg.sv
// Shared constants for the output-memory streamer: pixel geometry,
// memory word width and default image size.
package out_mem_streamer_pkg;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 16;
  localparam int MEM_DATA_W   = 128;
  localparam int ADDR_W       = 16;
  localparam int NUM_WORDS    = 4096;
endpackage

// File: rtl/out_mem_streamer_word_fifo2.sv
// Two-entry word FIFO between the memory read port and the pixel serializer.
// A push while full is accepted only when a pop happens in the same cycle.
module word_fifo2
  import out_mem_streamer_pkg::*;
#(
  parameter int W = MEM_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign count = count_q;

endmodule

// File: rtl/out_mem_streamer.sv
// Reads the equalized image back from output memory as wide words and
// serializes it into a one-pixel-per-beat valid/ready stream.
module out_mem_streamer
  import out_mem_streamer_pkg::*;
#(
  parameter int NUM_WORDS    = out_mem_streamer_pkg::NUM_WORDS,
  parameter int ADDR_W       = out_mem_streamer_pkg::ADDR_W,
  parameter int PIX_W        = out_mem_streamer_pkg::PIX_W,
  parameter int PIX_PER_WORD = out_mem_streamer_pkg::PIX_PER_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  output_wt_done,
  input  logic [MEM_DATA_W-1:0] out_mem_rd_data,
  output logic [ADDR_W-1:0]     out_mem_rd_addr,
  output logic                  out_mem_rd_en,
  output logic [PIX_W-1:0]      pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last,
  output logic                  stream_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_e;

  localparam int TOTAL_PIX = PIX_PER_WORD * NUM_WORDS;
  localparam int PCNT_W    = $clog2(TOTAL_PIX + 1);
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int IDX_W     = $clog2(PIX_PER_WORD);
  localparam logic [PCNT_W-1:0] LAST_PIX  = PCNT_W'(TOTAL_PIX - 1);
  localparam logic [WCNT_W-1:0] ALL_WORDS = WCNT_W'(NUM_WORDS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PIX_PER_WORD - 1);

  state_e                  state_q, state_d;
  logic [WCNT_W-1:0]       issued_q, issued_d;
  logic [PCNT_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    sr_vld_q, sr_vld_d;
  logic [MEM_DATA_W-1:0]   sr_q, sr_d;
  logic                    inflight_q, inflight_d;
  logic                    done_q, done_d;

  logic                    rd_en;
  logic                    xfer, last_beat, sr_free, is_last;
  logic [2:0]              occ;
  logic                    fifo_push, fifo_pop, fifo_clr;
  logic                    fifo_empty, fifo_full;
  logic [1:0]              fifo_count;
  logic [MEM_DATA_W-1:0]   fifo_dout;

  word_fifo2 #(.W(MEM_DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (out_mem_rd_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign is_last   = sr_vld_q && (pix_cnt_q == LAST_PIX);
  assign xfer      = sr_vld_q && pix_ready;
  assign last_beat = xfer && (idx_q == IDX_LAST);
  assign sr_free   = !sr_vld_q || last_beat;
  // Words owned by the block: in the serializer, queued, or still in flight.
  assign occ       = 3'(sr_vld_q) + 3'(fifo_count) + 3'(inflight_q);

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    pix_cnt_d = pix_cnt_q;
    idx_d     = idx_q;
    sr_vld_d  = sr_vld_q;
    sr_d      = sr_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && output_wt_done) begin
          state_d   = ST_STREAM;
          issued_d  = '0;
          pix_cnt_d = '0;
        end
      end
      ST_STREAM: begin
        rd_en = (issued_q < ALL_WORDS) && (occ < 3'd2);
        if (rd_en) issued_d = issued_q + 1'b1;
        if (xfer) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          idx_d     = idx_q + 1'b1;
        end
        // Refill on the same edge the final pixel of a word leaves; a word
        // arriving with nothing queued bypasses the FIFO.
        if (sr_free) begin
          idx_d = '0;
          if (!fifo_empty) begin
            sr_d     = fifo_dout;
            sr_vld_d = 1'b1;
            fifo_pop = 1'b1;
          end else if (inflight_q) begin
            sr_d     = out_mem_rd_data;
            sr_vld_d = 1'b1;
          end else begin
            sr_vld_d = 1'b0;
          end
        end
        fifo_push = inflight_q && !(sr_free && fifo_empty) && (!fifo_full || fifo_pop);
        if (xfer && is_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!output_wt_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d   = ST_IDLE;
      issued_d  = issued_q;
      sr_vld_d  = 1'b0;
      idx_d     = '0;
      done_d    = 1'b0;
      rd_en     = 1'b0;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      fifo_clr  = 1'b1;
    end

    inflight_d = rd_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      pix_cnt_q  <= '0;
      idx_q      <= '0;
      sr_vld_q   <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      pix_cnt_q  <= pix_cnt_d;
      idx_q      <= idx_d;
      sr_vld_q   <= sr_vld_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign out_mem_rd_en   = rd_en;
  assign out_mem_rd_addr = ADDR_W'(issued_q);
  assign pix_valid       = sr_vld_q;
  assign pix_data        = sr_vld_q ? sr_q[idx_q*PIX_W +: PIX_W] : '0;
  assign pix_last        = is_last;
  assign stream_done     = done_q;

endmodule

// File: tb/tb_out_mem_streamer.sv
// Randomized scoreboard bench for out_mem_streamer with a small image.
module tb_out_mem_streamer;
  localparam int NW    = 4;
  localparam int PPW   = 16;
  localparam int PW    = 8;
  localparam int AW    = 16;
  localparam int TOTAL = NW * PPW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic           output_wt_done = 1'b0;
  logic           pix_ready = 1'b1;
  logic [127:0]   rd_data = '0;
  logic [AW-1:0]  rd_addr;
  logic           rd_en;
  logic [PW-1:0]  pix_data;
  logic           pix_valid, pix_last, stream_done;

  out_mem_streamer #(.NUM_WORDS(NW), .ADDR_W(AW), .PIX_W(PW), .PIX_PER_WORD(PPW)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .output_wt_done  (output_wt_done),
    .out_mem_rd_data (rd_data),
    .out_mem_rd_addr (rd_addr),
    .out_mem_rd_en   (rd_en),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_last        (pix_last),
    .stream_done     (stream_done)
  );

  always #5 clk = ~clk;

  // Output memory: one-cycle read latency, garbage when not read.
  logic [127:0] mem [NW];
  always @(posedge clk)
    rd_data <= (rd_en && rd_addr < AW'(NW)) ? mem[rd_addr] : {$urandom, $urandom, $urandom, $urandom};

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int rd_issued = 0, acc = 0, done_seen = 0, exp_done_cyc = -100;
  int first_valid_cyc = -1, first_rd_cyc = -1, last_xfer_cyc = -1, start_cyc = 0;
  bit quiet_stab = 0, stab_armed = 0, ready_hold_off = 0;
  logic [7:0] prev_d;
  logic prev_l;
  int ready_mode = 0, stall_left = 0;
  bit tog = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_hold_off) pix_ready = 1'b0;
    else case (ready_mode)
      0: pix_ready = 1'b1;
      1: begin
        tog = !tog;
        if (stall_left > 0) begin
          stall_left--;
          pix_ready = 1'b0;
        end else begin
          if ($urandom_range(0, 49) == 0) stall_left = 20;
          pix_ready = tog;
        end
      end
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_addr", rd_addr == AW'(rd_issued), rd_addr, rd_issued);
        check("rd_in_range", rd_issued < NW, rd_issued, NW - 1);
        check("outstanding", (rd_issued - acc / PPW) < 2, rd_issued - acc / PPW, 1);
        rd_issued++;
      end
      if (stab_armed && !quiet_stab)
        check("hold_stable", pix_valid && pix_data == prev_d && pix_last == prev_l, pix_data, prev_d);
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pix_valid && pix_ready) begin
        check("extra_pixel", exp_q.size() > 0, acc, TOTAL);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("pix_data", pix_data == e.d, pix_data, e.d);
          check("pix_last", pix_last == e.l, pix_last, e.l);
        end
        acc++;
        last_xfer_cyc = cyc;
        if (pix_last) exp_done_cyc = cyc + 1;
      end
      if (stream_done || cyc == exp_done_cyc) begin
        check("stream_done", stream_done == (cyc == exp_done_cyc), stream_done, cyc == exp_done_cyc);
        if (stream_done) done_seen++;
      end
      stab_armed = pix_valid && !pix_ready;
      prev_d = pix_data;
      prev_l = pix_last;
    end
  end

  task automatic start_pass(input bit pattern, input bit hold);
    for (int k = 0; k < NW; k++)
      for (int j = 0; j < PPW; j++)
        mem[k][8*j +: 8] = pattern ? 8'(PPW*k + j) : 8'($urandom_range(0, 255));
    exp_q.delete();
    for (int n = 0; n < TOTAL; n++) begin
      exp_t e;
      e.d = mem[n / PPW][8*(n % PPW) +: 8];
      e.l = (n == TOTAL - 1);
      exp_q.push_back(e);
    end
    rd_issued = 0; acc = 0; first_valid_cyc = -1; first_rd_cyc = -1;
    @(posedge clk); #1;
    output_wt_done = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) output_wt_done = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 5000 && done_seen == d0; i++) @(posedge clk);
    check({name, "_done"}, done_seen != d0, done_seen - d0, 1);
    check({name, "_all_pixels"}, exp_q.size() == 0, exp_q.size(), 0);
    check({name, "_all_reads"}, rd_issued == NW, rd_issued, NW);
  endtask

  task automatic idle_window(input string name);
    int act;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_en || pix_valid || stream_done) act++;
    end
    check(name, act == 0, act, 0);
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 5000 && acc < n; i++) @(negedge clk);
    check("reach_pixel", acc >= n, acc, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {pix_valid, rd_en, pix_last, stream_done} == 4'b0, {pix_valid, rd_en, pix_last, stream_done}, 0);
    check("reset_data", pix_data == '0 && rd_addr == '0, pix_data, 0);
    reset = 1'b1;
    enable = 1'b1;

    // Basic full-rate pass with the ramp pattern
    ready_mode = 0;
    start_pass(1'b1, 1'b0);
    wait_done("basic");
    check("rd_latency", first_rd_cyc - start_cyc == 1, first_rd_cyc - start_cyc, 1);
    check("valid_latency", first_valid_cyc - start_cyc == 3, first_valid_cyc - start_cyc, 3);
    check("full_rate", last_xfer_cyc - first_valid_cyc + 1 == TOTAL, last_xfer_cyc - first_valid_cyc + 1, TOTAL);

    // Held output_wt_done must not re-trigger
    start_pass(1'b0, 1'b1);
    wait_done("hold");
    idle_window("retrigger_idle");
    @(posedge clk); #1;
    output_wt_done = 1'b0;
    repeat (2) @(posedge clk);

    // Backpressure: toggling with stalls, then random ready
    ready_mode = 1;
    start_pass(1'b0, 1'b0);
    wait_done("toggle_bp");
    ready_mode = 2;
    start_pass(1'b0, 1'b0);
    wait_done("random_bp");

    // Abort after pixel 20
    ready_mode = 0;
    start_pass(1'b0, 1'b0);
    wait_acc(21);
    ready_hold_off = 1'b1;
    quiet_stab = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("abort_valid_drop", pix_valid == 1'b0, pix_valid, 0);
    idle_window("abort_idle");
    @(posedge clk); #1;
    enable = 1'b1;
    ready_hold_off = 1'b0;
    @(negedge clk);
    quiet_stab = 1'b0;
    start_pass(1'b0, 1'b0);
    wait_done("after_abort");

    // Asynchronous reset at pixel 30
    start_pass(1'b0, 1'b0);
    wait_acc(31);
    quiet_stab = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("areset_ctrl", {pix_valid, rd_en, pix_last, stream_done} == 4'b0, {pix_valid, rd_en, pix_last, stream_done}, 0);
    check("areset_data", pix_data == '0 && rd_addr == '0, pix_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_window("post_reset_idle");
    quiet_stab = 1'b0;
    ready_mode = 2;
    start_pass(1'b0, 1'b0);
    wait_done("after_reset");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
